// File: rtl/kp_orient_hist.sv
// kp_orient_hist: 36-bin saturating gradient-orientation histogram with dominant-bin scan.
// Accepts one keypoint, accumulates N_SAMPLES gradients, then scans one bin per cycle.
module kp_orient_hist #(
    parameter int MAG_W     = 8,
    parameter int ACC_W     = 16,
    parameter int N_SAMPLES = 81,
    parameter int NBINS     = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kp_valid,
    output logic             kp_ready,
    input  logic [17:0]      kp_addr,
    input  logic             oct_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [MAG_W-1:0] grad_mag,
    input  logic [5:0]       grad_dir,
    output logic             dir_valid,
    output logic [5:0]       main_dir,
    output logic [17:0]      kp_addr_out,
    output logic             oct_out,
    output logic             busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_scan_idx;
    logic [5:0]       r_best_idx;
    logic [ACC_W-1:0] r_best_val;
    logic [ACC_W-1:0] r_bin [NBINS];

    logic             w_legal;
    logic [ACC_W-1:0] w_cur;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_sat;
    logic [ACC_W-1:0] w_scan_val;
    logic             w_gt;

    // Out-of-range directions read as zero and are never written back
    assign w_legal    = grad_dir < 6'(NBINS);
    assign w_cur      = w_legal ? r_bin[grad_dir] : '0;
    assign w_sum      = {1'b0, w_cur} + (ACC_W + 1)'(grad_mag);
    assign w_sat      = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign w_scan_val = r_bin[r_scan_idx];
    assign w_gt       = w_scan_val > r_best_val;

    assign kp_ready     = r_state == S_IDLE;
    assign sample_ready = r_state == S_ACCUM;
    assign dir_valid    = r_state == S_DONE;
    assign busy         = r_state != S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_scan_idx  <= '0;
            r_best_idx  <= '0;
            r_best_val  <= '0;
            main_dir    <= '0;
            kp_addr_out <= '0;
            oct_out     <= 1'b0;
            for (int b = 0; b < NBINS; b++) r_bin[b] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (kp_valid) begin
                    kp_addr_out <= kp_addr;
                    oct_out     <= oct_in;
                    r_cnt       <= '0;
                    r_state     <= S_ACCUM;
                    for (int b = 0; b < NBINS; b++) r_bin[b] <= '0;
                end
                S_ACCUM: if (sample_valid) begin
                    if (w_legal) r_bin[grad_dir] <= w_sat;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N_SAMPLES - 1)) begin
                        r_state    <= S_SCAN;
                        r_scan_idx <= '0;
                        r_best_idx <= '0;
                        r_best_val <= '0;
                    end
                end
                S_SCAN: begin
                    // Strict compare keeps the lowest index on ties
                    if (w_gt) begin
                        r_best_val <= w_scan_val;
                        r_best_idx <= r_scan_idx;
                    end
                    if (r_scan_idx == 6'(NBINS - 1)) begin
                        main_dir <= w_gt ? r_scan_idx : r_best_idx;
                        r_state  <= S_DONE;
                    end else begin
                        r_scan_idx <= r_scan_idx + 6'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kp_orient_hist.sv
// tb_kp_orient_hist: scoreboard bench with a plain-array histogram reference model.
// Narrow 8-bit accumulators are used so saturation is reachable within one keypoint.
module tb_kp_orient_hist;
    localparam int ACC_W = 8;
    localparam int NS    = 81;
    localparam int SATV  = (1 << ACC_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        kp_valid = 1'b0;
    logic        oct_in = 1'b0;
    logic        sample_valid = 1'b0;
    logic [17:0] kp_addr = '0;
    logic [7:0]  grad_mag = '0;
    logic [5:0]  grad_dir = '0;
    logic        kp_ready, sample_ready, dir_valid, oct_out, busy;
    logic [5:0]  main_dir;
    logic [17:0] kp_addr_out;

    typedef struct {
        int dir;
        int addr;
        int oct;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hist[36];
    int   scnt = 0;
    int   m_addr = 0;
    int   m_oct = 0;
    logic prev_dv = 1'b0;

    kp_orient_hist #(.MAG_W(8), .ACC_W(ACC_W), .N_SAMPLES(NS), .NBINS(36)) dut (
        .clk(clk), .rst(rst), .kp_valid(kp_valid), .kp_ready(kp_ready),
        .kp_addr(kp_addr), .oct_in(oct_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .grad_mag(grad_mag), .grad_dir(grad_dir),
        .dir_valid(dir_valid), .main_dir(main_dir), .kp_addr_out(kp_addr_out),
        .oct_out(oct_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int argmax();
        int b = 0;
        for (int i = 1; i < 36; i++) if (hist[i] > hist[b]) b = i;
        return b;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (prev_dv) begin
                chk("ready_after_done", int'(kp_ready), 1);
                chk("busy_after_done", int'(busy), 0);
            end
            if (dir_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dir_valid: got main_dir %0d expected no pulse", main_dir);
                end else begin
                    mon_e = sb.pop_front();
                    chk("main_dir", int'(main_dir), mon_e.dir);
                    chk("kp_addr_out", int'(kp_addr_out), mon_e.addr);
                    chk("oct_out", int'(oct_out), mon_e.oct);
                    chk("latency_cycle", cyc, mon_e.cyc);
                    chk("busy_in_done", int'(busy), 1);
                end
            end
            prev_dv <= dir_valid;
        end else begin
            prev_dv <= 1'b0;
        end
    end

    task automatic start_kp(input int a, input int o);
        int n = 0;
        @(negedge clk);
        while (!kp_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!kp_ready) begin
            checks++;
            errors++;
            $display("FAIL kp_ready_timeout: got 0 expected 1");
        end
        kp_valid = 1'b1;
        kp_addr  = 18'(a);
        oct_in   = 1'(o);
        @(negedge clk);
        kp_valid = 1'b0;
        m_addr = a;
        m_oct  = o;
        scnt   = 0;
        for (int i = 0; i < 36; i++) hist[i] = 0;
    endtask

    task automatic send_sample(input int d, input int m, input int gap);
        int   n = 0;
        exp_t x;
        repeat (gap) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
        @(negedge clk);
        while (!sample_ready && n < 100) begin
            sample_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!sample_ready) begin
            checks++;
            errors++;
            $display("FAIL sample_ready_timeout: got 0 expected 1");
        end
        sample_valid = 1'b1;
        grad_dir = 6'(d);
        grad_mag = 8'(m);
        if (d < 36) hist[d] = (hist[d] + m > SATV) ? SATV : hist[d] + m;
        scnt++;
        if (scnt == NS) begin
            x.dir  = argmax();
            x.addr = m_addr;
            x.oct  = m_oct;
            x.cyc  = cyc + 37;
            sb.push_back(x);
        end
    endtask

    task automatic end_samples();
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dir_valid"}, int'(dir_valid), 0);
        chk({tag, "_main_dir"}, int'(main_dir), 0);
        chk({tag, "_kp_addr_out"}, int'(kp_addr_out), 0);
        chk({tag, "_oct_out"}, int'(oct_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_kp_ready"}, int'(kp_ready), 1);
        chk({tag, "_sample_ready"}, int'(sample_ready), 0);
    endtask

    task automatic random_kp(input int a, input int o, input int maxgap);
        start_kp(a, o);
        for (int i = 0; i < NS; i++)
            send_sample($urandom_range(0, 40), $urandom_range(0, 15), $urandom_range(0, maxgap));
        end_samples();
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;

        // Single dominant direction
        start_kp(32'h12345, 1);
        for (int i = 0; i < NS; i++) send_sample(7, 10, 0);
        end_samples();

        // Asynchronous reset in the middle of accumulation
        start_kp(32'h2aaaa, 1);
        for (int i = 0; i < 40; i++) send_sample(9, 3, 0);
        end_samples();
        #2 rst = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        scnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Tie between bins 3 and 20 keeps the lower index
        start_kp(32'h00111, 0);
        for (int i = 0; i < 40; i++) send_sample(3, 5, 0);
        for (int i = 0; i < 40; i++) send_sample(20, 5, 0);
        send_sample(30, 0, 0);
        end_samples();

        // Saturation of bin 35 against a large bin 0
        start_kp(32'h20202, 1);
        for (int i = 0; i < 80; i++) send_sample(35, 255, 0);
        send_sample(0, 200, 0);
        end_samples();

        // Idle samples, illegal directions, and a keypoint request during SCAN
        repeat (5) begin
            @(negedge clk);
            sample_valid = 1'b1;
            grad_dir = 6'd5;
            grad_mag = 8'd200;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        start_kp(32'h0beef, 0);
        for (int i = 0; i < NS; i++) send_sample(40, $urandom_range(1, 255), 0);
        end_samples();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("kp_ready_in_scan", int'(kp_ready), 0);
            kp_valid = 1'b1;
            kp_addr  = 18'h3ffff;
            oct_in   = 1'b1;
        end
        @(negedge clk);
        kp_valid = 1'b0;
        oct_in   = 1'b0;
        start_kp(32'h00042, 0);
        for (int i = 0; i < NS; i++) send_sample(i % 3 == 0 ? 12 : 40, 2, 0);
        end_samples();

        // Back-to-back keypoints with samples gapped one in three cycles
        start_kp(32'h00abc, 0);
        for (int i = 0; i < NS; i++) send_sample(i % 36, i, 2);
        end_samples();
        start_kp(32'h3f00f, 1);
        for (int i = 0; i < NS; i++) send_sample(17 + (i % 2), 1 + (i % 5), 2);
        end_samples();

        for (int k = 0; k < 4; k++) random_kp($urandom_range(0, 18'h3ffff), k % 2, 2);

        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
